// File: rtl/alu_mdu.sv
// ============================================================================
// alu_mdu : execute-stage ALU with iterative unsigned multiply/divide (HI/LO)
//           and a start/busy/done handshake. ALU_MDU_DIV_EN enables DIVU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alucont,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_nbits = CW'(WIDTH);
  localparam logic [CW-1:0] c_one   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
`ifdef ALU_MDU_DIV_EN
    , S_DIV = 2'd2
`endif
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dbz;

  logic [WIDTH-1:0]     w_alu;
  logic [WIDTH-1:0]     w_sub;
  logic                 w_slt;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;

  // SLT is sign(a-b) corrected by the signed-overflow flag of the subtraction
  assign w_sub = a - b;
  assign w_slt = w_sub[WIDTH-1] ^
                 ((a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]));

  always_comb begin
    w_alu = '0;
    case (alucont)
      3'b000:  w_alu = a & b;
      3'b001:  w_alu = a | b;
      3'b010:  w_alu = a + b;
      3'b110:  w_alu = w_sub;
      3'b111:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu = '0;
    endcase
  end

  // Shift-add: upper half accumulates the multiplicand, lower half holds the
  // not-yet-consumed multiplier bits, whole accumulator shifts right.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

`ifdef ALU_MDU_DIV_EN
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_next;

  // Restoring step on {remainder, dividend}; a set MSB of the trial means borrow
  assign w_diff     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
  assign w_div_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (alucont == 3'b101) begin
              r_state <= S_MUL;
              r_cnt   <= c_nbits;
              r_acc   <= {{WIDTH{1'b0}}, b};
              r_opb   <= a;
            end
`ifdef ALU_MDU_DIV_EN
            else if (alucont == 3'b011) begin
              if (b == '0) begin
                r_lo     <= '1;
                r_hi     <= a;
                r_result <= '1;
                r_dbz    <= 1'b1;
                r_done   <= 1'b1;
              end else begin
                r_state <= S_DIV;
                r_cnt   <= c_nbits;
                r_acc   <= {{WIDTH{1'b0}}, a};
                r_opb   <= b;
              end
            end
`endif
            else begin
              r_result <= w_alu;
              r_dbz    <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - c_one;
          if (r_cnt == c_one) begin
            r_hi     <= w_mul_next[2*WIDTH-1:WIDTH];
            r_lo     <= w_mul_next[WIDTH-1:0];
            r_result <= w_mul_next[WIDTH-1:0];
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - c_one;
          if (r_cnt == c_one) begin
            r_hi     <= w_div_next[2*WIDTH-1:WIDTH];
            r_lo     <= w_div_next[WIDTH-1:0];
            r_result <= w_div_next[WIDTH-1:0];
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign result      = r_result;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// tb_alu_mdu : directed self-checking bench for alu_mdu (WIDTH = 32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  alucont;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alucont     (alucont),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one accepted single-cycle op; afterwards we sit in the done cycle
  task automatic op1(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; alucont = op; a = va; b = vb;
    tick();
    start = 1'b0; a = 32'h5A5A_A5A5; b = 32'hC3C3_3C3C;
  endtask

  // long op: returns number of edges after acceptance until done (bounded)
  task automatic oplong(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int lat);
    op1(op, va, vb);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic bad;
    reset = 1'b1; start = 1'b0; alucont = 3'b000; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    // single-cycle ops
    op1(3'b010, 32'd5, 32'd7);
    check("add_done", {31'd0, done}, 32'd1);
    check("add_busy", {31'd0, busy}, 32'd0);
    check("add_res", result, 32'd12);
    tick();
    check("add_done_pulse", {31'd0, done}, 32'd0);
    check("add_hold", result, 32'd12);

    op1(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_res", result, 32'h00F0_1200);
    op1(3'b001, 32'hF000_0001, 32'h0000_0010);
    check("or_res", result, 32'hF000_0011);
    op1(3'b110, 32'd3, 32'd5);
    check("sub_res", result, 32'hFFFF_FFFE);
    op1(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    check("slt_ovf0", result, 32'd0);
    op1(3'b111, 32'hFFFF_FFFF, 32'd1);
    check("slt_neg1", result, 32'd1);
    op1(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_ovf1", result, 32'd1);
    op1(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("unused_res", result, 32'd0);
    check("unused_done", {31'd0, done}, 32'd1);
    check("single_hi", hi, 32'd0);
    check("single_lo", lo, 32'd0);
    tick();

    // MULTU 0xFFFFFFFF * 2 with an ignored ADD at cycle 5, then back-to-back ADD
    op1(3'b101, 32'hFFFF_FFFF, 32'd2);
    check("mul_busy0", {31'd0, busy}, 32'd1);
    bad = 1'b0;
    for (int j = 1; j < 32; j++) begin
      if (j == 5) begin start = 1'b1; alucont = 3'b010; a = 32'd1; b = 32'd1; end
      tick();
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    check("mul_busy_window", {31'd0, bad}, 32'd0);
    tick();
    check("mul_done", {31'd0, done}, 32'd1);
    check("mul_busy_end", {31'd0, busy}, 32'd0);
    check("mul_hi", hi, 32'd1);
    check("mul_lo", lo, 32'hFFFF_FFFE);
    check("mul_res", result, 32'hFFFF_FFFE);
    op1(3'b010, 32'd1, 32'd1);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_res", result, 32'd2);
    check("b2b_hi", hi, 32'd1);
    check("b2b_lo", lo, 32'hFFFF_FFFE);
    tick();
    check("b2b_pulse", {31'd0, done}, 32'd0);

    oplong(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mul2_lat", lat, 32'd32);
    check("mul2_hi", hi, 32'hFFFF_FFFE);
    check("mul2_lo", lo, 32'h0000_0001);
    oplong(3'b101, 32'h0001_0000, 32'h0001_0000, lat);
    check("mul3_hi", hi, 32'd1);
    check("mul3_lo", lo, 32'd0);
    tick();

`ifdef ALU_MDU_DIV_EN
    oplong(3'b011, 32'd100, 32'd7, lat);
    check("div_lat", lat, 32'd32);
    check("div_lo", lo, 32'd14);
    check("div_hi", hi, 32'd2);
    check("div_res", result, 32'd14);
    check("div_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    op1(3'b011, 32'd100, 32'd0);
    check("dbz_done", {31'd0, done}, 32'd1);
    check("dbz_busy", {31'd0, busy}, 32'd0);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    check("dbz_hi", hi, 32'd100);
    check("dbz_res", result, 32'hFFFF_FFFF);
    check("dbz_flag", {31'd0, div_by_zero}, 32'd1);
    op1(3'b010, 32'd4, 32'd4);
    check("dbz_clear", {31'd0, div_by_zero}, 32'd0);
    check("dbz_add", result, 32'd8);
`else
    op1(3'b011, 32'd100, 32'd7);
    check("nodiv_done", {31'd0, done}, 32'd1);
    check("nodiv_busy", {31'd0, busy}, 32'd0);
    check("nodiv_res", result, 32'd0);
    check("nodiv_hi", hi, 32'd1);
    check("nodiv_lo", lo, 32'd0);
    check("nodiv_dbz", {31'd0, div_by_zero}, 32'd0);
    op1(3'b011, 32'd100, 32'd0);
    check("nodiv_dbz0", {31'd0, div_by_zero}, 32'd0);
    check("nodiv_lo0", lo, 32'd0);
`endif
    tick();

    // reset at cycle 10 of a MULTU
    op1(3'b101, 32'd3, 32'd3);
    for (int j = 1; j < 10; j++) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_hi", hi, 32'd0);
    check("mrst_lo", lo, 32'd0);
    check("mrst_res", result, 32'd0);
    tick();
    reset = 1'b0;
    op1(3'b010, 32'd2, 32'd3);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_res", result, 32'd5);
    check("post_rst_hi", hi, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle ALU for the pipelined MIPS core's execute stage. Single-cycle logic/arithmetic ops keep the existing `alucont` encoding. The block adds an iterative unsigned multiply/divide unit that writes HI/LO registers, and a start/busy/done handshake so the pipeline can stall on long operations. Signed set-less-than is overflow-correct.

## Interface

- `WIDTH`, 32, operand/result width in bits (≥ 4).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Accepted on a rising edge when `busy` = 0.
- `alucont`  in  3  operation code, sampled with `start`.
- `a`, `b`  in  WIDTH each  operands, sampled with `start`.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse: `result` (and HI/LO, if applicable) updated.
- `result`  out  WIDTH  registered result. Held until the next `done`.
- `hi`, `lo`  out  WIDTH each  HI/LO registers.
- `div_by_zero`  out  1  valid with `done`. Set only for a divide with `b` = 0.

Clock and reset: one clock (`clk`). `reset` is asynchronous and active-high.

## Operation

- **Operation codes**
  - 000 AND.
  - 001 OR.
  - 010 ADD, mod 2^WIDTH.
  - 110 SUB, mod 2^WIDTH.
  - 111 SLT: `result` = 1 if `a` < `b` signed, else 0. Computed as sign(a−b) XOR overflow(a−b).
  - 101 MULTU.
  - 011 DIVU.
  - All other codes: `result` = 0.
- **Single-cycle ops** (all codes except 101/011)
  - Handled entirely in IDLE. `result` is written and `done` pulses. `hi`/`lo` are unchanged.
- **State machine** (states IDLE, MUL, DIV)
  - IDLE → MUL on an accepted `start` with `alucont` = 101.
  - IDLE → DIV on an accepted `start` with `alucont` = 011 and `b` ≠ 0.
  - MUL/DIV → IDLE when the bit counter reaches 0.
  - `busy` = (state ≠ IDLE).
- **MULTU**
  - Shift-add algorithm, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
  - On completion: `hi` = product[2W-1:W], `lo` = product[W-1:0], `result` = `lo`.
- **DIVU**
  - Restoring division, one quotient bit per cycle.
  - On completion: `lo` = quotient, `hi` = remainder, `result` = quotient.
- **Divide by zero**
  - Completes in IDLE in one cycle. `lo` = all-ones, `hi` = `a`, `result` = all-ones, `div_by_zero` = 1.
- `start` while `busy` = 1 is ignored; no queueing. Operands are latched internally, so `a`/`b` may change after acceptance.
- `div_by_zero` is cleared on every other `done`.

## Timing

- Reset values: `busy` = 0, `done` = 0, `result` = 0, `hi` = 0, `lo` = 0, `div_by_zero` = 0, state IDLE, counter 0.
- Single-cycle ops and divide-by-zero: `start` accepted at edge k; `done` = 1 in the cycle after edge k, with `result` valid.
- MULTU/DIVU latency:
  - `start` accepted at edge k.
  - `busy` = 1 for cycles k+1 … k+WIDTH.
  - At edge k+WIDTH the results are written, `done` = 1, and `busy` returns to 0.
  - Latency is exactly WIDTH cycles.
- Back-to-back: since `busy` = 0 during the `done` cycle, a new `start` in that cycle is accepted with no bubble.
- `done` is high for exactly one cycle per accepted operation. It is never asserted without a preceding accepted `start`.
- Reset mid-operation: aborts immediately (asynchronous). All outputs return to reset values; the partial result is discarded. The next `start` is accepted on the first edge after `reset` deasserts.

## Configuration

- `ALU_MDU_DIV_EN` defined: DIVU (011) implemented as above, including the DIV state and divide-by-zero handling.
- `ALU_MDU_DIV_EN` undefined:
  - 011 behaves as an unused code: single-cycle, `result` = 0, `done` pulses.
  - `hi`/`lo` are unchanged and `div_by_zero` stays 0.
  - No divider logic or DIV state is synthesised.

## Test plan

All scenarios use WIDTH = 32.

- **ADD:** `a` = 5, `b` = 7, `alucont` 010 → next cycle `result` = 12, `done` = 1 for one cycle, `busy` stays 0.
- **SLT overflow cases:**
  - `a` = 0x7FFFFFFF, `b` = 0x80000000 → `result` = 0.
  - `a` = 0xFFFFFFFF, `b` = 1 → `result` = 1.
- **MULTU:** `a` = 0xFFFFFFFF, `b` = 2, `alucont` 101 →
  - `busy` high 32 cycles; a `start` with ADD at cycle 5 is ignored.
  - `done` at cycle 32 with `hi` = 1, `lo` = 0xFFFFFFFE, `result` = 0xFFFFFFFE.
- **DIVU** (`ALU_MDU_DIV_EN` defined):
  - `a` = 100, `b` = 7 → after 32 cycles `lo` = 14, `hi` = 2, `div_by_zero` = 0.
  - `a` = 100, `b` = 0 → after 1 cycle `lo` = 0xFFFFFFFF, `hi` = 100, `div_by_zero` = 1.
- **Reset mid-operation:** assert `reset` at cycle 10 of a MULTU → `busy` = 0, `done` = 0, `hi` = `lo` = `result` = 0 immediately. ADD 2+3 after release → `result` = 5 one cycle later.
- **Back-to-back:** issue ADD 1+1 in the `done` cycle of a MULTU → accepted, `done` pulses again the following cycle with `result` = 2, `hi`/`lo` hold the product.
